// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sizing helpers, lane packing and sequencer state encoding
package fft_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int log2n(input int n);
    return clog2(n);
  endfunction

  function automatic int beats(input int n, input int p);
    return n / (2 * p);
  endfunction

  function automatic int stage_w(input int n);
    return (clog2(clog2(n)) < 1) ? 1 : clog2(clog2(n));
  endfunction

  function automatic int beat_w(input int n, input int p);
    return (clog2(beats(n, p)) < 1) ? 1 : clog2(beats(n, p));
  endfunction

  // Lane 0 sits in the most significant slot of the output beat.
  function automatic int lane_lsb(input int p, input int nbits, input int l);
    return (p - 1 - l) * 2 * nbits;
  endfunction

  function automatic int round_away(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // Elaboration-time table generators; never evaluated in hardware.
  function automatic int tw_re(input int nbits, input int n, input int k);
    real amp, ang;
    amp = real'((1 << (nbits - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
    return round_away(amp * $cos(ang));
  endfunction

  function automatic int tw_im(input int nbits, input int n, input int k);
    real amp, ang;
    amp = real'((1 << (nbits - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
    return round_away(-amp * $sin(ang));
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// rtl/twiddle_rom.sv - combinational twiddle lookup, k to {re, im} for k in 0..N/2-1
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int N     = 8
) (
  input  logic [clog2(N)-2:0] k,
  output logic [NBITS-1:0]    re,
  output logic [NBITS-1:0]    im
);

  localparam int DEPTH = N / 2;

  logic [NBITS-1:0] re_tab [DEPTH];
  logic [NBITS-1:0] im_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam int RE_V = tw_re(NBITS, N, g);
    localparam int IM_V = tw_im(NBITS, N, g);
    assign re_tab[g] = RE_V[NBITS-1:0];
    assign im_tab[g] = IM_V[NBITS-1:0];
  end

  assign re = re_tab[k];
  assign im = im_tab[k];

endmodule

// File: rtl/twiddle_sequencer.sv
// rtl/twiddle_sequencer.sv - radix-2 DIF twiddle streamer, P lanes per beat with stage stride addressing
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int N     = 8,
  parameter int P     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [stage_w(N)-1:0]   stage,
  input  logic                    inverse,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [P*2*NBITS-1:0]    coeff_out,
  output logic                    last,
  output logic                    busy,
  output logic                    done
);

  localparam int LOG2N = log2n(N);
  localparam int BEATS = beats(N, P);
  localparam int SW    = stage_w(N);
  localparam int BW    = beat_w(N, P);
  localparam int KW    = LOG2N - 1;
  localparam logic [BW-1:0] BEAT_MAX  = BW'(BEATS - 1);
  localparam logic [SW-1:0] STAGE_MAX = SW'(LOG2N - 1);

  logic [1:0]           state;
  logic [BW-1:0]        cnt, nxt_cnt;
  logic [SW-1:0]        stg, end_stg, nxt_stg;
  logic                 inv_q, nxt_last, legal;
  logic [P*2*NBITS-1:0] coeff_nxt;

  assign legal = mode || (32'(stage) < 32'(LOG2N));
  assign done  = (state == ST_DONE);

  // Position of the beat to load next: the current one on the first load, else its successor.
  always_comb begin
    nxt_cnt = cnt;
    nxt_stg = stg;
    if (out_valid) begin
      if (cnt == BEAT_MAX) begin
        nxt_cnt = '0;
        nxt_stg = stg + SW'(1);
      end else begin
        nxt_cnt = cnt + BW'(1);
      end
    end
    nxt_last = (nxt_cnt == BEAT_MAX) && (nxt_stg == end_stg);
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic [KW-1:0]    b, k;
    logic [NBITS-1:0] re, im;
    assign b = KW'(int'(nxt_cnt) * P + l);
    // b mod (N >> (s+1)) is a mask of the low bits; the shift restores the stride.
    assign k = (b & ({KW{1'b1}} >> nxt_stg)) << nxt_stg;
    twiddle_rom #(.NBITS(NBITS), .N(N)) u_rom (.k(k), .re(re), .im(im));
    assign coeff_nxt[lane_lsb(P, NBITS, l) +: 2*NBITS] = {re, inv_q ? -im : im};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      coeff_out <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      stg       <= '0;
      end_stg   <= '0;
      inv_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && legal) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            inv_q   <= inverse;
            cnt     <= '0;
            stg     <= mode ? '0 : stage;
            end_stg <= mode ? STAGE_MAX : stage;
          end
        end
        ST_RUN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            coeff_out <= coeff_nxt;
            last      <= nxt_last;
          end else if (out_ready) begin
            if (last) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              last      <= 1'b0;
            end else begin
              cnt       <= nxt_cnt;
              stg       <= nxt_stg;
              coeff_out <= coeff_nxt;
              last      <= nxt_last;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_sequencer.sv
// tb/tb_twiddle_sequencer.sv - directed N=8 sequences plus randomized N=16 runs against a trig model
module tb_twiddle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, mode_a, inverse_a, ready_a;
  logic [1:0]  stage_a;
  logic        valid_a, last_a, busy_a, done_a;
  logic [31:0] coeff_a;
  logic        start_b, mode_b, inverse_b, ready_b;
  logic [1:0]  stage_b;
  logic        valid_b, last_b, busy_b, done_b;
  logic [63:0] coeff_b;

  twiddle_sequencer #(.NBITS(8), .N(8), .P(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .stage(stage_a),
    .inverse(inverse_a), .out_ready(ready_a), .out_valid(valid_a),
    .coeff_out(coeff_a), .last(last_a), .busy(busy_a), .done(done_a)
  );

  twiddle_sequencer #(.NBITS(8), .N(16), .P(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .stage(stage_b),
    .inverse(inverse_b), .out_ready(ready_b), .out_valid(valid_b),
    .coeff_out(coeff_b), .last(last_b), .busy(busy_b), .done(done_b)
  );

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [31:0] got_q[$];
  bit          last_q[$];
  logic [31:0] exp_a[$];
  int          done_cnt, done_cyc, acc_cyc, reached, n_acc, dn;
  logic        busy_at_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // Reference beat for N=16, P=4, NBITS=8 straight from the twiddle definition.
  function automatic logic [63:0] model_beat(input int s, input int t, input bit inv);
    logic [63:0] r;
    int b, k, re, im;
    real ang;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      b   = t * 4 + l;
      k   = (b % (16 >> (s + 1))) * (1 << s);
      ang = 2.0 * 3.141592653589793 * k / 16.0;
      re  = rnd(127.0 * $cos(ang));
      im  = rnd(-127.0 * $sin(ang));
      if (inv) im = -im;
      r = {r[47:0], re[7:0], im[7:0]};
    end
    return r;
  endfunction

  task automatic start_a_run(input bit m, input logic [1:0] s, input bit inv);
    mode_a = m; stage_a = s; inverse_a = inv; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic collect_a(input int hold, input logic [31:0] hold_exp, input bit restart);
    int held;
    held = 0;
    got_q.delete(); last_q.delete();
    done_cnt = 0; done_cyc = -1; acc_cyc = -2; busy_at_done = 1'bx;
    for (int cyc = 0; cyc < 40; cyc++) begin
      start_a = restart && (cyc == 1 || done_a);
      if (done_a) begin
        done_cnt++; done_cyc = cyc; busy_at_done = busy_a;
      end
      if (valid_a && held < hold) begin
        ready_a = 1'b0;
        held++;
        check("hold_data", coeff_a, hold_exp);
        check("hold_last", last_a, 0);
      end else begin
        ready_a = 1'b1;
      end
      if (valid_a && ready_a) begin
        got_q.push_back(coeff_a); last_q.push_back(last_a); acc_cyc = cyc;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic check_run(input string tag, input int lmask);
    int lm;
    lm = 0;
    check({tag, "_count"}, got_q.size(), exp_a.size());
    foreach (exp_a[i]) check({tag, "_beat"}, (i < got_q.size()) ? got_q[i] : 32'hx, exp_a[i]);
    foreach (last_q[i]) if (last_q[i]) lm |= (1 << i);
    check({tag, "_last"}, lm, lmask);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_cyc, acc_cyc + 1);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  initial begin
    rst = 1'b0;
    start_a = 0; mode_a = 0; inverse_a = 0; stage_a = 0; ready_a = 1;
    start_b = 0; mode_b = 0; inverse_b = 0; stage_b = 0; ready_b = 1;
    repeat (3) @(negedge clk);
    check("rst_valid", valid_a, 0);
    check("rst_coeff", coeff_a, 0);
    check("rst_last", last_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_coeff_b", coeff_b, 0);
    rst = 1'b1;
    @(negedge clk);

    start_a_run(1'b1, 2'd0, 1'b0);
    check("lat_valid", valid_a, 0);
    check("lat_busy", busy_a, 1);
    collect_a(0, 32'h0, 1'b0);
    exp_a = '{32'h7F005AA6, 32'h0081A6A6, 32'h7F000081, 32'h7F000081, 32'h7F007F00, 32'h7F007F00};
    check_run("allst", 32);

    start_a_run(1'b0, 2'd0, 1'b1);
    collect_a(0, 32'h0, 1'b0);
    exp_a = '{32'h7F005A5A, 32'h007FA65A};
    check_run("inv", 2);

    start_a_run(1'b0, 2'd1, 1'b0);
    collect_a(3, 32'h7F000081, 1'b0);
    exp_a = '{32'h7F000081, 32'h7F000081};
    check_run("stall", 2);

    start_a_run(1'b0, 2'd0, 1'b0);
    mode_a = 1'b1; stage_a = 2'd2; inverse_a = 1'b1;
    collect_a(0, 32'h0, 1'b1);
    exp_a = '{32'h7F005AA6, 32'h0081A6A6};
    check_run("restart", 2);

    mode_a = 1'b0; stage_a = 2'd3; inverse_a = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("illegal_busy", busy_a, 0);
    collect_a(0, 32'h0, 1'b0);
    check("illegal_beats", got_q.size(), 0);
    check("illegal_done", done_cnt, 0);

    start_a_run(1'b1, 2'd0, 1'b0);
    reached = 0; n_acc = 0;
    for (int cyc = 0; cyc < 20 && reached == 0; cyc++) begin
      ready_a = 1'b1;
      if (valid_a && n_acc == 2) begin
        check("beat3", coeff_a, 32'h7F000081);
        reached = 1; rst = 1'b0;
      end else if (valid_a) begin
        n_acc++;
      end
      @(negedge clk);
    end
    check("rst_reach", reached, 1);
    check("midrst_valid", valid_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_coeff", coeff_a, 0);
    check("midrst_last", last_a, 0);
    rst = 1'b1;
    dn = 0;
    repeat (5) begin
      if (done_a) dn++;
      @(negedge clk);
    end
    check("midrst_no_done", dn, 0);
    start_a_run(1'b1, 2'd0, 1'b0);
    collect_a(0, 32'h0, 1'b0);
    exp_a = '{32'h7F005AA6, 32'h0081A6A6, 32'h7F000081, 32'h7F000081, 32'h7F007F00, 32'h7F007F00};
    check_run("after_rst", 32);

    for (int run = 0; run < 1000; run++) begin
      bit          m, inv, seen;
      int          s;
      logic [63:0] q[$];
      logic [63:0] exp_b;
      m = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 3);
      inv = 1'($urandom_range(0, 1));
      q.delete();
      for (int st = (m ? 0 : s); st <= (m ? 3 : s); st++)
        for (int t = 0; t < 2; t++) q.push_back(model_beat(st, t, inv));
      mode_b = m; stage_b = 2'(s); inverse_b = inv; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
        mode_b = 1'($urandom_range(0, 1));
        stage_b = 2'($urandom_range(0, 3));
        inverse_b = 1'($urandom_range(0, 1));
        ready_b = ($urandom_range(0, 9) < 7);
        if (done_b) begin
          seen = 1'b1;
          check("rand_left", q.size(), 0);
        end else if (valid_b && ready_b) begin
          if (q.size() == 0) begin
            check("rand_extra", 1, 0);
          end else begin
            exp_b = q.pop_front();
            check("rand_beat", coeff_b, exp_b);
            check("rand_last", last_b, q.size() == 0);
          end
        end
        @(negedge clk);
      end
      check("rand_done", seen, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
